s_window_loader: RTL and testbench

S_WINDOW_LOADER -- requirements
Module: s_window_loader

---
 rtl/FIR_pkg.sv | 13 +
 rtl/s_window_loader.sv | 116 +++++++++++
 tb/tb_s_window_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/FIR_pkg.sv
// Shared FIR front-end types: window-loader state encoding and adder sizing.
package FIR_pkg;

   localparam int unsigned MCA_MAX_ADDITIONS = 16;
   localparam int unsigned WCNT_W            = 16;

   typedef enum logic [1:0] {
      LDR_IDLE  = 2'd0,
      LDR_START = 2'd1,
      LDR_BUSY  = 2'd2
   } state_ldr_e;

endpackage

// File: rtl/s_window_loader.sv
// Double-buffered loader for 2-bit control-symbol windows feeding the multi-cycle adder;
// the next window fills while the active one is held stable for the adder.
module s_window_loader
   import FIR_pkg::*;
#(
   parameter int unsigned NUM_ADDITIONS = 16,
   parameter int unsigned MCA_CYCLES    = MCA_MAX_ADDITIONS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              s_valid,
   input  logic [1:0]        s_data,
   output logic              s_ready,
   output logic              start,
   output logic              S_values [NUM_ADDITIONS*2-1:0],
   output logic              busy,
   output logic [WCNT_W-1:0] window_count
);

   localparam int unsigned BUF_W  = NUM_ADDITIONS * 2;
   localparam int unsigned FCNT_W = (NUM_ADDITIONS > 1) ? $clog2(NUM_ADDITIONS) : 1;
   localparam int unsigned BCNT_W = (MCA_CYCLES > 1) ? $clog2(MCA_CYCLES) : 1;
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(NUM_ADDITIONS - 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MCA_CYCLES - 1);

   state_ldr_e         state_q, state_d;
   logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
   logic [FCNT_W-1:0]  fill_cnt_q;
   logic               fill_full_q;
   logic [BUF_W-1:0]   fill_q;
   logic [BUF_W-1:0]   active_q;
   logic [WCNT_W-1:0]  wc_q;
   logic               xfer;
   logic               launch;
   logic               accept;

   assign s_ready      = enable && !fill_full_q;
   assign accept       = s_valid && s_ready;
   assign start        = (state_q == LDR_START);
   assign busy         = (state_q == LDR_START) || (state_q == LDR_BUSY);
   assign window_count = wc_q;

   // State register and adder busy counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LDR_IDLE;
         bcnt_q  <= '0;
      end else if (enable) begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // Next state: a full fill buffer is only handed over from idle
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      xfer    = 1'b0;
      launch  = 1'b0;
      case (state_q)
         LDR_IDLE: begin
            if (fill_full_q) begin
               xfer    = 1'b1;
               state_d = LDR_START;
            end
         end
         LDR_START: begin
            launch  = 1'b1;
            bcnt_d  = '0;
            state_d = LDR_BUSY;
         end
         LDR_BUSY: begin
            if (bcnt_q == BCNT_LAST) begin
               bcnt_d  = '0;
               state_d = LDR_IDLE;
            end else begin
               bcnt_d = bcnt_q + BCNT_W'(1);
            end
         end
         default: state_d = LDR_IDLE;
      endcase
   end

   // Fill/active buffers; accept never coincides with transfer since fill_full blocks s_ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q      <= '0;
         active_q    <= '0;
         fill_cnt_q  <= '0;
         fill_full_q <= 1'b0;
         wc_q        <= '0;
      end else if (enable) begin
         if (xfer) begin
            active_q    <= fill_q;
            fill_full_q <= 1'b0;
            fill_cnt_q  <= '0;
         end else if (accept) begin
            fill_q[{fill_cnt_q, 1'b0} +: 2] <= s_data;
            if (fill_cnt_q == FCNT_LAST) begin
               fill_full_q <= 1'b1;
            end else begin
               fill_cnt_q <= fill_cnt_q + FCNT_W'(1);
            end
         end
         if (launch) begin
            wc_q <= wc_q + WCNT_W'(1);
         end
      end
   end

   for (genvar i = 0; i < int'(BUF_W); i++) begin : g_unpack
      assign S_values[i] = active_q[i];
   end

endmodule

// File: tb/tb_s_window_loader.sv
// Randomized scoreboard bench for s_window_loader against a window/countdown reference model.
module tb_s_window_loader;

   localparam int unsigned N   = 16;
   localparam int unsigned MCA = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        s_valid;
   logic [1:0]  s_data;
   logic        s_ready;
   logic        start;
   logic        busy;
   logic        S_values [2*N-1:0];
   logic [15:0] window_count;

   always #5 clk = ~clk;

   s_window_loader #(.NUM_ADDITIONS(N), .MCA_CYCLES(MCA)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .start        (start),
      .S_values     (S_values),
      .busy         (busy),
      .window_count (window_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: beats collected into windows; m_run counts adder cycles left
   // (MCA+1 right after launch = start cycle, then MCA busy cycles, 0 = idle).
   int              m_run = 0;
   bit              m_full = 1'b0;
   logic [1:0]      m_beats [$];
   logic [2*N-1:0]  exp_q [$];
   logic [2*N-1:0]  cur_active = '0;
   logic [15:0]     exp_wc = '0;
   bit              prev_start = 1'b0;

   function automatic logic [2*N-1:0] pack_s();
      logic [2*N-1:0] p;
      for (int i = 0; i < int'(2*N); i++) p[i] = S_values[i];
      return p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model advances on the same edge as the DUT.
   task automatic step(input bit v, input logic [1:0] d, input bit en, output bit acc);
      logic [2*N-1:0] w;
      @(negedge clk);
      s_valid = v;
      s_data  = d;
      enable  = en;
      acc = v && en && !m_full;
      @(posedge clk);
      if (en) begin
         if (m_run > 0) m_run--;
         else if (m_full) begin
            m_run  = MCA + 1;
            m_full = 1'b0;
         end
         if (acc) begin
            m_beats.push_back(d);
            if (m_beats.size() == N) begin
               for (int i = 0; i < int'(N); i++) w[2*i +: 2] = m_beats[i];
               exp_q.push_back(w);
               m_beats.delete();
               m_full = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b1, a);
   endtask

   task automatic feed(input int n);
      bit a;
      int sent = 0;
      for (int i = 0; i < 40 * n && sent < n; i++) begin
         step(1'b1, 2'($urandom), 1'b1, a);
         if (a) sent++;
      end
      chk("feed_budget", 32'(sent), 32'(n));
   endtask

   task automatic run_until(input int run_val);
      bit a;
      int i;
      for (i = 0; i < 100 && m_run != run_val; i++) step(1'b0, 2'b00, 1'b1, a);
      chk("wait_budget", 32'(m_run), 32'(run_val));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3;
      rst     = 1'b1;
      s_valid = 1'b0;
      #1;
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_window_count", 32'(window_count), 32'd0);
      chk("rst_S_values", pack_s(), 32'd0);
      m_run = 0;
      m_full = 1'b0;
      m_beats.delete();
      exp_q.delete();
      cur_active = '0;
      exp_wc = '0;
      @(negedge clk);
      #3;
      rst = 1'b0;
   endtask

   // Monitor: cycle-level handshake/flag checks plus window scoreboard on each start
   initial begin
      logic [2*N-1:0] w;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev_start = 1'b0;
         end else begin
            chk("s_ready", 32'(s_ready), 32'(enable && !m_full));
            chk("start", 32'(start), 32'(m_run == int'(MCA) + 1));
            chk("busy", 32'(busy), 32'(m_run > 0));
            if (start && !prev_start) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL window_pop: start with no expected window at %0t", $time);
               end else begin
                  w = exp_q.pop_front();
                  chk("window_S_values", pack_s(), w);
                  cur_active = w;
               end
               chk("window_count", 32'(window_count), 32'(exp_wc));
               exp_wc = exp_wc + 16'd1;
            end else if (busy) begin
               chk("S_values_hold", pack_s(), cur_active);
            end
            prev_start = start;
         end
      end
   end

   initial begin
      bit a;
      rst = 1'b1; enable = 1'b1; s_valid = 1'b0; s_data = 2'b00;
      #2;
      chk("por_start", 32'(start), 32'd0);
      chk("por_S_values", pack_s(), 32'd0);
      do_reset();

      // Sequential symbols k[1:0]
      for (int k = 0; k < int'(N); k++) step(1'b1, 2'(k), 1'b1, a);
      idle(25);
      chk("seq_window_count", 32'(window_count), 32'd1);

      // 48-beat stream with valid held high
      feed(48);
      idle(60);
      chk("stream_window_count", 32'(window_count), 32'd4);

      // Window B loaded during A's busy period, then random traffic
      feed(16);
      feed(16);
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 9) < 7), 2'($urandom), ($urandom_range(0, 9) != 0), a);
      idle(60);

      // Enable low for 5 cycles at bcnt=7
      feed(16);
      run_until(int'(MCA) - 7);
      for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b0, a);
      idle(30);

      // Reset mid-fill, then mid-busy, then a short fill must not launch
      feed(9);
      do_reset();
      chk("rst_fill_ready", 32'(s_ready), 32'(enable));
      feed(16);
      run_until(int'(MCA) - 3);
      do_reset();
      feed(15);
      idle(30);
      chk("no_start_wc", 32'(window_count), 32'd0);
      feed(1);
      idle(25);

      // window_count wrap from a preloaded value
      force dut.wc_q = 16'hFFFE;
      #1;
      release dut.wc_q;
      exp_wc = 16'hFFFE;
      feed(16);
      feed(16);
      idle(40);
      chk("wrap_window_count", 32'(window_count), 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
